// File: rtl/jtvigil_sndctrl.sv
// jtvigil_sndctrl: sound CPU glue -- main/sound latch, IRQ vector, sample ROM port and DAC.
module jtvigil_sndctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        main_latch_wr,
  input  logic [7:0]  main_dout,
  input  logic [7:0]  snd_a,
  input  logic        snd_iorq_n,
  input  logic        snd_rd_n,
  input  logic        snd_wr_n,
  input  logic        snd_m1_n,
  input  logic [7:0]  snd_dout,
  input  logic        fm_irq_n,
  output logic [7:0]  io_dout,
  output logic        io_cs,
  output logic        snd_int_n,
  output logic        snd_wait_n,
  output logic [15:0] sample_addr,
  output logic        sample_cs,
  input  logic [7:0]  sample_data,
  input  logic        sample_ok,
  output logic [7:0]  dac
);
  logic [7:0]  latch_q, latch_d, dac_q, dac_d, io_dout_q, io_dout_d, vec;
  logic [15:0] addr_q, addr_d;
  logic        pend_q, pend_d, latch_wr_q, wr_n_q, ack_q, rd4_q, ok_q, ok_d;
  logic        io_cs_q, io_cs_d, int_n_q, int_n_d;
  logic        io_sel, ack, rd_sel, rd4, wr_fall, cap, clr;

  assign io_sel  = !snd_iorq_n && snd_m1_n && snd_a[7];
  assign ack     = !snd_iorq_n && !snd_m1_n;
  assign rd_sel  = io_sel && !snd_rd_n;
  assign rd4     = rd_sel && snd_a[2:0] == 3'd4;
  assign wr_fall = io_sel && wr_n_q && !snd_wr_n;
  assign cap     = main_latch_wr && !latch_wr_q;
  assign clr     = wr_fall && snd_a[2:0] == 3'd3;
  assign vec     = {2'b11, ~pend_q, fm_irq_n, 4'hf};

  always_comb begin
    pend_d   = cap | (pend_q & ~clr);
    latch_d  = cap ? main_dout : latch_q;
    dac_d    = (wr_fall && snd_a[2:0] == 3'd2) ? snd_dout : dac_q;
    addr_d   = (rd4_q && !rd4) ? addr_q + 16'd1 : addr_q;
    addr_d[7:0]  = (wr_fall && snd_a[2:0] == 3'd0) ? snd_dout : addr_d[7:0];
    addr_d[15:8] = (wr_fall && snd_a[2:0] == 3'd1) ? snd_dout : addr_d[15:8];
    ok_d     = rd4 & (ok_q | sample_ok);
    io_cs_d  = ack | rd_sel;
    int_n_d  = &vec;
    // the acknowledge vector is frozen on its first cycle; sample data is held once delivered
    io_dout_d = ack ? (ack_q ? io_dout_q : vec) :
                !rd_sel ? 8'hff :
                snd_a[2:0] == 3'd0 ? latch_q :
                snd_a[2:0] == 3'd4 ? ((sample_ok && !ok_q) ? sample_data : io_dout_q) :
                8'hff;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      latch_q    <= 8'h00;
      pend_q     <= 1'b0;
      dac_q      <= 8'h80;
      addr_q     <= 16'h0000;
      io_dout_q  <= 8'hff;
      io_cs_q    <= 1'b0;
      int_n_q    <= 1'b1;
      latch_wr_q <= 1'b1;
      wr_n_q     <= 1'b0;
      ack_q      <= 1'b0;
      rd4_q      <= 1'b0;
      ok_q       <= 1'b0;
    end else begin
      latch_q    <= latch_d;
      pend_q     <= pend_d;
      dac_q      <= dac_d;
      addr_q     <= addr_d;
      io_dout_q  <= io_dout_d;
      io_cs_q    <= io_cs_d;
      int_n_q    <= int_n_d;
      latch_wr_q <= main_latch_wr;
      wr_n_q     <= snd_wr_n;
      ack_q      <= ack;
      rd4_q      <= rd4;
      ok_q       <= ok_d;
    end
  end

  // wait and ROM request are combinational so the Z80 stalls in the same cycle the read appears
  assign snd_wait_n  = rst | !(rd4 && !sample_ok && !ok_q);
  assign sample_cs   = rd4 & ~rst;
  assign io_dout     = io_dout_q;
  assign io_cs       = io_cs_q;
  assign snd_int_n   = int_n_q;
  assign sample_addr = addr_q;
  assign dac         = dac_q;
endmodule

// File: tb/tb_jtvigil_sndctrl.sv
// tb_jtvigil_sndctrl: scenario tasks with a queue of expected read/acknowledge bytes.
module tb_jtvigil_sndctrl;
  logic        clk = 0, rst = 1, main_latch_wr = 0, fm_irq_n = 1, sample_ok = 0;
  logic        snd_iorq_n = 1, snd_rd_n = 1, snd_wr_n = 1, snd_m1_n = 1;
  logic [7:0]  main_dout = 0, snd_a = 0, snd_dout = 0, sample_data = 0;
  logic [7:0]  io_dout, dac;
  logic        io_cs, snd_int_n, snd_wait_n, sample_cs;
  logic [15:0] sample_addr;
  int          checks = 0, failures = 0;
  logic [7:0]  exp_q[$];

  jtvigil_sndctrl dut (
    .clk(clk), .rst(rst), .main_latch_wr(main_latch_wr), .main_dout(main_dout),
    .snd_a(snd_a), .snd_iorq_n(snd_iorq_n), .snd_rd_n(snd_rd_n), .snd_wr_n(snd_wr_n),
    .snd_m1_n(snd_m1_n), .snd_dout(snd_dout), .fm_irq_n(fm_irq_n), .io_dout(io_dout),
    .io_cs(io_cs), .snd_int_n(snd_int_n), .snd_wait_n(snd_wait_n), .sample_addr(sample_addr),
    .sample_cs(sample_cs), .sample_data(sample_data), .sample_ok(sample_ok), .dac(dac)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_idle;
    snd_iorq_n = 1; snd_rd_n = 1; snd_wr_n = 1; snd_m1_n = 1;
  endtask

  task automatic io_wr(input logic [7:0] a, input logic [7:0] d);
    snd_a = a; snd_dout = d; snd_iorq_n = 0; snd_wr_n = 0;
    tick(2);
    bus_idle();
    tick();
  endtask

  task automatic io_rd(input logic [7:0] a, output logic [7:0] d, output logic cs);
    snd_a = a; snd_iorq_n = 0; snd_rd_n = 0;
    tick();
    d = io_dout; cs = io_cs;
    bus_idle();
    tick();
  endtask

  task automatic int_ack(output logic [7:0] d, output logic cs);
    snd_iorq_n = 0; snd_m1_n = 0;
    tick();
    d = io_dout; cs = io_cs;
    bus_idle();
    tick();
  endtask

  task automatic test_reset;
    main_latch_wr = 1;
    tick(2);
    checks += 7;
    if (dac !== 8'h80) begin failures++; $display("FAIL reset_dac got=%h exp=80", dac); end
    if (io_dout !== 8'hff) begin failures++; $display("FAIL reset_io_dout got=%h exp=ff", io_dout); end
    if (io_cs !== 1'b0) begin failures++; $display("FAIL reset_io_cs got=%b exp=0", io_cs); end
    if (snd_int_n !== 1'b1) begin failures++; $display("FAIL reset_int_n got=%b exp=1", snd_int_n); end
    if (snd_wait_n !== 1'b1) begin failures++; $display("FAIL reset_wait_n got=%b exp=1", snd_wait_n); end
    if (sample_cs !== 1'b0) begin failures++; $display("FAIL reset_sample_cs got=%b exp=0", sample_cs); end
    if (sample_addr !== 16'h0000) begin failures++; $display("FAIL reset_addr got=%h exp=0000", sample_addr); end
    rst = 0;
    tick(3);
    checks++;
    if (snd_int_n !== 1'b1) begin failures++; $display("FAIL reset_primed_latch got=%b exp=1", snd_int_n); end
    main_latch_wr = 0;
    tick();
  endtask

  task automatic test_latch;
    logic [7:0] d, e;
    logic cs;
    main_dout = 8'h3c; main_latch_wr = 1;
    tick(5);
    checks++;
    if (snd_int_n !== 1'b0) begin failures++; $display("FAIL latch_int_n got=%b exp=0", snd_int_n); end
    exp_q.push_back(8'hdf);
    int_ack(d, cs);
    e = exp_q.pop_front();
    checks += 2;
    if (d !== e) begin failures++; $display("FAIL latch_ack got=%h exp=%h", d, e); end
    if (cs !== 1'b1) begin failures++; $display("FAIL latch_ack_cs got=%b exp=1", cs); end
    checks++;
    if (snd_int_n !== 1'b0) begin failures++; $display("FAIL ack_keeps_source got=%b exp=0", snd_int_n); end
    exp_q.push_back(8'h3c);
    io_rd(8'h80, d, cs);
    e = exp_q.pop_front();
    checks++;
    if (d !== e) begin failures++; $display("FAIL latch_read got=%h exp=%h", d, e); end
    io_wr(8'h83, 8'h00);
    tick(2);
    checks++;
    if (snd_int_n !== 1'b1) begin failures++; $display("FAIL latch_single_capture got=%b exp=1", snd_int_n); end
    main_latch_wr = 0;
    tick();
  endtask

  task automatic test_irq;
    logic [7:0] d, e;
    logic cs;
    main_dout = 8'h11; main_latch_wr = 1;
    tick();
    main_latch_wr = 0; fm_irq_n = 0;
    tick(2);
    exp_q.push_back(8'hcf);
    int_ack(d, cs);
    e = exp_q.pop_front();
    checks++;
    if (d !== e) begin failures++; $display("FAIL irq_both got=%h exp=%h", d, e); end
    io_wr(8'h83, 8'h00);
    exp_q.push_back(8'hef);
    int_ack(d, cs);
    e = exp_q.pop_front();
    checks++;
    if (d !== e) begin failures++; $display("FAIL irq_fm_only got=%h exp=%h", d, e); end
    fm_irq_n = 1;
    tick();
    checks++;
    if (snd_int_n !== 1'b1) begin failures++; $display("FAIL irq_release got=%b exp=1", snd_int_n); end
  endtask

  task automatic test_same_cycle;
    logic [7:0] d, e;
    logic cs;
    main_dout = 8'h77;
    snd_a = 8'h83; snd_iorq_n = 0; snd_wr_n = 0; main_latch_wr = 1;
    tick(2);
    bus_idle(); main_latch_wr = 0;
    tick(2);
    checks++;
    if (snd_int_n !== 1'b0) begin failures++; $display("FAIL same_cycle_pend got=%b exp=0", snd_int_n); end
    exp_q.push_back(8'hdf);
    int_ack(d, cs);
    e = exp_q.pop_front();
    checks++;
    if (d !== e) begin failures++; $display("FAIL same_cycle_ack got=%h exp=%h", d, e); end
    io_wr(8'h83, 8'h00);
    tick(2);
  endtask

  task automatic test_sample;
    logic [7:0] e;
    io_wr(8'h80, 8'hff);
    io_wr(8'h81, 8'hff);
    checks++;
    if (sample_addr !== 16'hffff) begin failures++; $display("FAIL sample_addr_load got=%h exp=ffff", sample_addr); end
    snd_a = 8'h84; snd_iorq_n = 0; snd_rd_n = 0; sample_ok = 0;
    #1;
    checks += 2;
    if (sample_cs !== 1'b1) begin failures++; $display("FAIL sample_cs_start got=%b exp=1", sample_cs); end
    if (snd_wait_n !== 1'b0) begin failures++; $display("FAIL sample_wait_start got=%b exp=0", snd_wait_n); end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (snd_wait_n !== 1'b0) begin failures++; $display("FAIL sample_wait_hold cyc=%0d got=%b exp=0", i, snd_wait_n); end
    end
    sample_ok = 1; sample_data = 8'ha7;
    exp_q.push_back(8'ha7);
    #1;
    checks++;
    if (snd_wait_n !== 1'b1) begin failures++; $display("FAIL sample_wait_ok got=%b exp=1", snd_wait_n); end
    tick();
    sample_ok = 0; sample_data = 8'h00;
    tick();
    e = exp_q.pop_front();
    checks += 4;
    if (io_dout !== e) begin failures++; $display("FAIL sample_data got=%h exp=%h", io_dout, e); end
    if (io_cs !== 1'b1) begin failures++; $display("FAIL sample_io_cs got=%b exp=1", io_cs); end
    if (snd_wait_n !== 1'b1) begin failures++; $display("FAIL sample_wait_after got=%b exp=1", snd_wait_n); end
    if (sample_cs !== 1'b1) begin failures++; $display("FAIL sample_cs_hold got=%b exp=1", sample_cs); end
    bus_idle();
    #1;
    checks++;
    if (sample_cs !== 1'b0) begin failures++; $display("FAIL sample_cs_end got=%b exp=0", sample_cs); end
    tick();
    checks++;
    if (sample_addr !== 16'h0000) begin failures++; $display("FAIL sample_addr_wrap got=%h exp=0000", sample_addr); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] d, e;
    logic cs;
    exp_q.push_back(8'hff);
    io_rd(8'h85, d, cs);
    e = exp_q.pop_front();
    checks += 2;
    if (d !== e) begin failures++; $display("FAIL other_port got=%h exp=%h", d, e); end
    if (cs !== 1'b1) begin failures++; $display("FAIL other_port_cs got=%b exp=1", cs); end
    io_rd(8'h04, d, cs);
    checks++;
    if (cs !== 1'b0) begin failures++; $display("FAIL undecoded_cs got=%b exp=0", cs); end
    exp_q.push_back(8'hff);
    snd_iorq_n = 0; snd_m1_n = 0;
    tick();
    fm_irq_n = 0;
    tick(2);
    e = exp_q.pop_front();
    checks++;
    if (io_dout !== e) begin failures++; $display("FAIL ack_frozen got=%h exp=%h", io_dout, e); end
    bus_idle(); fm_irq_n = 1;
    tick(2);
  endtask

  task automatic test_dac_reset;
    io_wr(8'h82, 8'h5a);
    checks++;
    if (dac !== 8'h5a) begin failures++; $display("FAIL dac_write got=%h exp=5a", dac); end
    main_dout = 8'h01; main_latch_wr = 1;
    tick();
    main_latch_wr = 0;
    snd_iorq_n = 0; snd_m1_n = 0;
    tick(2);
    rst = 1;
    #1;
    checks += 3;
    if (dac !== 8'h80) begin failures++; $display("FAIL dac_reset got=%h exp=80", dac); end
    if (snd_int_n !== 1'b1) begin failures++; $display("FAIL int_reset got=%b exp=1", snd_int_n); end
    if (io_cs !== 1'b0) begin failures++; $display("FAIL io_cs_reset got=%b exp=0", io_cs); end
    bus_idle();
    tick();
    rst = 0;
    tick();
  endtask

  task automatic test_reset_mid_read;
    io_wr(8'h80, 8'h34);
    io_wr(8'h81, 8'h12);
    checks++;
    if (sample_addr !== 16'h1234) begin failures++; $display("FAIL mid_addr_load got=%h exp=1234", sample_addr); end
    snd_a = 8'h84; snd_iorq_n = 0; snd_rd_n = 0; sample_ok = 0;
    tick(2);
    checks++;
    if (snd_wait_n !== 1'b0) begin failures++; $display("FAIL mid_stall got=%b exp=0", snd_wait_n); end
    #2 rst = 1;
    #1;
    checks += 2;
    if (snd_wait_n !== 1'b1) begin failures++; $display("FAIL mid_wait_async got=%b exp=1", snd_wait_n); end
    if (sample_cs !== 1'b0) begin failures++; $display("FAIL mid_cs_async got=%b exp=0", sample_cs); end
    tick();
    bus_idle();
    tick();
    rst = 0;
    tick(2);
    checks++;
    if (sample_addr !== 16'h0000) begin failures++; $display("FAIL mid_no_inc got=%h exp=0000", sample_addr); end
  endtask

  initial begin
    test_reset();
    test_latch();
    test_irq();
    test_same_cycle();
    test_sample();
    test_back_to_back();
    test_dac_reset();
    test_reset_mid_read();
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/jtvigil_sndctrl.md
JTVIGIL_SNDCTRL -- requirements
Module: jtvigil_sndctrl

Interface
REQ-001 clk  in  1  system clock; every register updates on its rising edge.
REQ-002 rst  in  1  reset, asynchronous, active-high.
REQ-003 main_latch_wr  in  1  main CPU sound-latch write strobe; a level, high for the whole I/O write cycle.
REQ-004 main_dout  in  8  main CPU data bus; valid while main_latch_wr is high.
REQ-005 snd_a  in  8  sound Z80 address bits A[7:0].
REQ-006 snd_iorq_n, snd_rd_n, snd_wr_n, snd_m1_n  in  1 each  sound Z80 bus strobes, active-low.
REQ-007 snd_dout  in  8  sound Z80 write data.
REQ-008 fm_irq_n  in  1  YM2151 interrupt, active-low level.
REQ-009 io_dout  out  8  registered read data for sound Z80 I/O reads and interrupt-acknowledge cycles.
REQ-010 io_cs  out  1  registered; high when io_dout must be selected onto the sound Z80 data bus.
REQ-011 snd_int_n  out  1  sound Z80 INT, active-low.
REQ-012 snd_wait_n  out  1  sound Z80 WAIT, active-low.
REQ-013 sample_addr  out  16  sample ROM byte address.
REQ-014 sample_cs  out  1  sample ROM request.
REQ-015 sample_data  in  8  sample ROM data; valid when sample_ok is high.
REQ-016 sample_ok  in  1  sample ROM data valid.
REQ-017 dac  out  8  unsigned sample DAC level.

Function
REQ-018 Port decode applies only when snd_iorq_n=0 and snd_m1_n=1. Decoded ports need snd_a[7]=1 and use snd_a[2:0]:
  - read 0: latch read
  - write 0: sample_addr[7:0]
  - write 1: sample_addr[15:8]
  - write 2: dac
  - write 3: latch IRQ clear
  - read 4: sample read
  - all other reads: io_dout=FF
REQ-019 Latch capture:
  - Capture happens on the rising edge of main_latch_wr (0->1 edge detect, one capture per write cycle).
  - latch <= main_dout and latch_pend <= 1.
  - A level held high over several cycles captures once only.
REQ-020 Latch release: a port-3 write clears latch_pend, once per write cycle, detected on the falling edge of snd_wr_n.
REQ-021 If a capture and a clear occur in the same cycle, the capture wins and latch_pend=1.
REQ-022 Latch reads return the current latch value and do not change latch_pend.
REQ-023 Interrupt vector is FF with these bits cleared: bit4 cleared when fm_irq_n=0 (EF, RST 28h); bit5 cleared when latch_pend=1 (DF, RST 18h); both sources give CF.
REQ-024 snd_int_n=0 whenever vector != FF. It is registered, one cycle after the source changes.
REQ-025 Interrupt acknowledge (snd_iorq_n=0 and snd_m1_n=0):
  - io_cs=1 and io_dout=vector, with the vector frozen at the first cycle of the acknowledge.
  - An acknowledge does not clear any source.
REQ-026 Sample read, port-4 read:
  - sample_cs=1 from the first cycle of the read.
  - snd_wait_n=0 while sample_ok=0.
  - Once sample_ok=1: io_dout=sample_data, snd_wait_n=1, and sample_cs stays high until snd_rd_n rises.
REQ-027 On the rising edge of snd_rd_n that ends a port-4 read, sample_addr increments by 1 and wraps FFFF->0000.
REQ-028 A sample_addr byte write during an outstanding sample read is not possible (the bus is stalled); it needs no handling beyond a last-write-wins rule.
REQ-029 Port-2 writes load dac with snd_dout when snd_wr_n falls.
REQ-030 The io_cs/io_dout latency is 1 clk from the cycle the decode becomes valid. io_cs=0 for undecoded cycles.

Reset
REQ-031 While rst=1 all of the following hold:
  - latch=00, latch_pend=0
  - sample_addr=0000, dac=80
  - io_dout=FF, io_cs=0
  - snd_int_n=1, snd_wait_n=1, sample_cs=0
  - edge detectors primed so that a strobe already active at reset release does not fire
REQ-032 Reset asserted mid-sample-read drops snd_wait_n and sample_cs at once (asynchronous), and sample_addr does not increment.

Verification
REQ-033 main_latch_wr held high 5 cycles with main_dout=3C -> one capture, latch_pend=1, snd_int_n=0, acknowledge returns DF, port-0 read returns 3C.
REQ-034 latch pending plus fm_irq_n=0 -> acknowledge io_dout=CF; then port-3 write -> next acknowledge EF; then fm_irq_n=1 -> snd_int_n=1 within 1 clk.
REQ-035 Capture rising edge in the same cycle as a port-3 write falling edge -> latch_pend=1.
REQ-036 Write addr FFFF, then port-4 read with sample_ok delayed 4 clks -> snd_wait_n low exactly while sample_ok=0, io_dout=sample_data, after snd_rd_n rises sample_addr=0000.
REQ-037 Port-2 write of 5A -> dac=5A; apply rst -> dac=80, snd_int_n=1, io_cs=0.
REQ-038 rst pulsed during a stalled port-4 read at addr 1234 -> snd_wait_n=1 and sample_cs=0 immediately, sample_addr=0000 after reset, no increment.
